// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner with full-frame debounce, key-code decode and octave select.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat key_valid pulses while a key is held.
module keypad_matrix_scan #(
    parameter int SCAN_DIV      = 27000,
    parameter int DEBOUNCE      = 20,
    parameter int REPEAT_FRAMES = 50
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    output logic [3:0] col_out,
    input  logic [3:0] row_in,
    output logic       IsPressed,
    output logic [3:0] keyboard_data,
    output logic       key_valid,
    output logic [1:0] scale
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_PRE = DIV_W'(SCAN_DIV - 2);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] DEB_PRE = CNT_W'(DEBOUNCE - 1);

    // SAMPLE is the divider's last cycle; column advance happens in that same cycle.
    typedef enum logic {
        S_DRIVE  = 1'b0,
        S_SAMPLE = 1'b1
    } scan_state_t;

    scan_state_t      scan_state, scan_state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic             sample_en;

    logic [3:0]       row_meta, row_sync;
    logic [15:0]      snapshot, prev;
    logic [CNT_W-1:0] stable_cnt;
    logic             frame_end_q;

    logic             same, zero, one_hot, accept;
    logic [3:0]       key_idx, code, step_code;
    logic             kv_new, rep_fire, fire;
    logic [1:0]       scale_d;

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:    key_code = 4'h1;
            4'd1:    key_code = 4'h2;
            4'd2:    key_code = 4'h3;
            4'd3:    key_code = 4'hA;
            4'd4:    key_code = 4'h4;
            4'd5:    key_code = 4'h5;
            4'd6:    key_code = 4'h6;
            4'd7:    key_code = 4'hB;
            4'd8:    key_code = 4'h7;
            4'd9:    key_code = 4'h8;
            4'd10:   key_code = 4'h9;
            4'd11:   key_code = 4'hC;
            4'd12:   key_code = 4'hE;
            4'd13:   key_code = 4'h0;
            4'd14:   key_code = 4'hF;
            default: key_code = 4'hD;
        endcase
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scan_state <= S_DRIVE;
            div_q      <= '0;
            col_q      <= 2'd0;
        end else begin
            scan_state <= scan_state_d;
            div_q      <= div_d;
            col_q      <= col_d;
        end
    end

    always_comb begin
        scan_state_d = scan_state;
        div_d        = div_q;
        col_d        = col_q;
        sample_en    = 1'b0;
        case (scan_state)
            S_DRIVE: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == DIV_PRE) scan_state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                sample_en    = 1'b1;
                div_d        = '0;
                col_d        = col_q + 2'd1;
                scan_state_d = S_DRIVE;
            end
            default: scan_state_d = S_DRIVE;
        endcase
    end

    assign col_out = ~(4'b0001 << col_q);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            snapshot <= '0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
            if (sample_en) begin
                for (int r = 0; r < 4; r++) snapshot[r*4 + int'(col_q)] <= ~row_sync[r];
            end
        end
    end

    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) key_idx = 4'(i);
        end
    end

    assign same    = (snapshot == prev);
    assign zero    = (snapshot == '0);
    assign one_hot = !zero && ((snapshot & (snapshot - 16'd1)) == '0);
    assign accept  = frame_end_q && same && (stable_cnt == DEB_PRE);
    assign code    = key_code(key_idx);
    assign kv_new  = accept && one_hot && ((code != keyboard_data) || !IsPressed);

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_PRE = REP_W'(REPEAT_FRAMES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_clear, rep_tick;

    assign rep_clear = accept && (zero || kv_new);
    assign rep_tick  = frame_end_q && IsPressed && !rep_clear;
    assign rep_fire  = rep_tick && (rep_cnt == REP_PRE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || rep_clear || rep_fire) rep_cnt <= '0;
        else if (rep_tick)                    rep_cnt <= rep_cnt + REP_W'(1);
    end
`else
    assign rep_fire = (REPEAT_FRAMES < 0);
`endif

    // key_valid is a one-cycle strobe with no ready: consumers must take it in the cycle it is high.
    assign fire      = kv_new || rep_fire;
    assign step_code = kv_new ? code : keyboard_data;

    always_comb begin
        scale_d = scale;
        if (fire) begin
            if (step_code == 4'hA && scale != 2'd0)      scale_d = scale - 2'd1;
            else if (step_code == 4'hB && scale != 2'd2) scale_d = scale + 2'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            prev          <= '0;
            stable_cnt    <= '0;
            frame_end_q   <= 1'b0;
            IsPressed     <= 1'b0;
            keyboard_data <= 4'd0;
            key_valid     <= 1'b0;
            scale         <= 2'd1;
        end else begin
            frame_end_q <= sample_en && (col_q == 2'd3);
            key_valid   <= fire;
            scale       <= scale_d;
            if (frame_end_q) begin
                if (!same) begin
                    prev       <= snapshot;
                    stable_cnt <= '0;
                end else if (stable_cnt != DEB_MAX) begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end
            // Ghost / multi-key patterns leave every output untouched.
            if (accept) begin
                if (zero) begin
                    IsPressed <= 1'b0;
                end else if (one_hot) begin
                    IsPressed     <= 1'b1;
                    keyboard_data <= code;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Randomised bench for keypad_matrix_scan: a frame-level keypad model predicts every key_valid
// event and the held outputs, a monitor pops the expected-event queue on each pulse.
module tb_keypad_matrix_scan;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RF = 2;
    localparam int FR = 4 * SD;
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                            4'h4, 4'h5, 4'h6, 4'hB,
                                            4'h7, 4'h8, 4'h9, 4'hC,
                                            4'hE, 4'h0, 4'hF, 4'hD};

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] col_out;
    logic [3:0] row_in;
    logic       IsPressed;
    logic [3:0] keyboard_data;
    logic       key_valid;
    logic [1:0] scale;

    logic [15:0] keys = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [21:0] exp_q[$];

    logic [15:0] m_snap, m_last;
    int          m_run, m_rep;
    logic        m_pressed;
    logic [3:0]  m_data;
    logic [1:0]  m_scale;

    keypad_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_FRAMES(RF)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .col_out      (col_out),
        .row_in       (row_in),
        .IsPressed    (IsPressed),
        .keyboard_data(keyboard_data),
        .key_valid    (key_valid),
        .scale        (scale)
    );

    // Clock / reset
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= sys_rst ? 0 : cyc + 1;

    // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Reference model
    task automatic model_reset();
        m_snap    = '0;
        m_last    = '0;
        m_run     = 1;
        m_rep     = 0;
        m_pressed = 1'b0;
        m_data    = 4'd0;
        m_scale   = 2'd1;
        exp_q.delete();
    endtask

    task automatic emit(input logic [3:0] c);
        if (c == 4'hA && m_scale > 0) m_scale = m_scale - 2'd1;
        if (c == 4'hB && m_scale < 2) m_scale = m_scale + 2'd1;
        exp_q.push_back({16'(cyc + 4), c, m_scale});
    endtask

    task automatic model_frame();
        int         n;
        int         idx;
        logic [3:0] c;
        logic       was_pressed;
        logic       cleared;
        was_pressed = m_pressed;
        cleared     = 1'b0;
        if (m_snap == m_last) m_run++;
        else begin
            m_last = m_snap;
            m_run  = 1;
        end
        if (m_run == DB + 1) begin
            n = $countones(m_snap);
            if (n == 0) begin
                m_pressed = 1'b0;
                cleared   = 1'b1;
            end else if (n == 1) begin
                idx = 0;
                for (int i = 0; i < 16; i++) if (m_snap[i]) idx = i;
                c = KEYMAP[idx];
                if (c != m_data || !m_pressed) begin
                    emit(c);
                    cleared = 1'b1;
                end
                m_pressed = 1'b1;
                m_data    = c;
            end
        end
        if (cleared || !was_pressed) m_rep = 0;
        else begin
            m_rep++;
`ifdef KEYPAD_REPEAT_EN
            if (m_rep == RF) begin
                emit(m_data);
                m_rep = 0;
            end
`endif
        end
    endtask

    // Column k of frame f sees the keys as they were at cycle 16f + 4k + 1 (two-flop synchroniser).
    always @(negedge sys_clk) begin
        int         ph;
        logic [3:0] exp_col;
        if (sys_rst) model_reset();
        else begin
            ph      = cyc % FR;
            exp_col = 4'b0001 << ((cyc / SD) % 4);
            exp_col = ~exp_col;
            chk("col_out", {28'd0, col_out}, {28'd0, exp_col});
            if (ph == 1) begin
                chk("is_pressed", {31'd0, IsPressed}, {31'd0, m_pressed});
                chk("keyboard_data", {28'd0, keyboard_data}, {28'd0, m_data});
                chk("scale", {30'd0, scale}, {30'd0, m_scale});
            end
            if (ph % SD == 1) begin
                for (int r = 0; r < 4; r++) m_snap[r*4 + ph/SD] = keys[r*4 + ph/SD];
            end
            if (ph == FR - 3) model_frame();
        end
    end

    // Scoreboard monitor
    always @(negedge sys_clk) begin
        logic [21:0] e;
        if (!sys_rst) begin
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL key_valid_unexpected: got pulse code %0h scale %0d at cycle %0d, required none",
                             keyboard_data, scale, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_valid_event", {10'd0, cyc[15:0], keyboard_data, scale}, {10'd0, e});
                end
            end else if (exp_q.size() != 0 && exp_q[0][21:6] == cyc[15:0]) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL key_valid_missing: got no pulse at cycle %0d, required code %0h scale %0d",
                         cyc, e[5:2], e[1:0]);
            end
        end
    end

    // Driver tasks
    task automatic do_reset();
        sys_rst = 1'b1;
        tick(1);
        chk("rst_col_out", {28'd0, col_out}, 32'hE);
        chk("rst_is_pressed", {31'd0, IsPressed}, 32'd0);
        chk("rst_keyboard_data", {28'd0, keyboard_data}, 32'd0);
        chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_scale", {30'd0, scale}, 32'd1);
        tick(1);
        sys_rst = 1'b0;
    endtask

    task automatic press_latency(input logic [15:0] pat, input logic [3:0] c);
        bit found = 0;
        keys = pat;
        for (int i = 0; i < 5 * FR + 3 && !found; i++) begin
            @(negedge sys_clk);
            if (IsPressed && keyboard_data == c) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL press_latency: got no acceptance of %0h within %0d cycles, required acceptance", c, 5 * FR + 3);
        end
        tick(1);
    endtask

    task automatic tap(input logic [15:0] pat, input int hold_frames, input int rel_frames);
        keys = pat;
        tick(hold_frames * FR);
        keys = '0;
        tick(rel_frames * FR);
    endtask

    // Stimulus
    initial begin
        logic [1:0] exp_a [3];
        logic [1:0] exp_b [3];
        logic [15:0] pat;
        int kind;
        exp_a = '{2'd0, 2'd0, 2'd0};
        exp_b = '{2'd1, 2'd2, 2'd2};

        do_reset();
        tick(6 * FR);

        tick($urandom_range(1, FR));
        press_latency(16'h0020, 4'h5);
        tick(4 * FR);
        keys = '0;
        tick(6 * FR);

        for (int i = 0; i < 4; i++) begin
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            tick(20);
        end
        tap(16'h0020, 6, 6);

        tap(16'h0011, 6, 6);
        keys = 16'h0020;
        tick(6 * FR);
        tap(16'h0031, 6, 6);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            tap(16'h0008, 6, 6);
            chk("scale_after_a", {30'd0, scale}, {30'd0, exp_a[i]});
        end
        for (int i = 0; i < 3; i++) begin
            tap(16'h0080, 6, 6);
            chk("scale_after_b", {30'd0, scale}, {30'd0, exp_b[i]});
        end

        keys = 16'h0100;
        tick(FR + FR / 2);
        do_reset();
        keys = '0;
        tick(6 * FR);

        tap(16'h0004, 10, 6);
        chk("data_after_release", {28'd0, keyboard_data}, 32'h3);
        chk("pressed_after_release", {31'd0, IsPressed}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)      pat = 16'd1 << $urandom_range(0, 15);
            else if (kind < 8) pat = '0;
            else               pat = (16'd1 << $urandom_range(0, 7)) | (16'd1 << $urandom_range(8, 15));
            keys = pat;
            tick($urandom_range(8, 6 * FR));
        end

        keys = '0;
        tick(8 * FR);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
